// File: rtl/bf16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : bf16_pkg
// | Brief    : Shared bf16 types, driver FSM encoding and well-known constants.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
package bf16_pkg;

    localparam int BF16_W = 16;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef struct packed {
        bf16_t a;
        bf16_t b;
    } bf16_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } drv_state_e;

    localparam bf16_t BF16_ONE  = 16'h3F80;
    localparam bf16_t BF16_QNAN = 16'hFFC0;
    localparam bf16_t BF16_PINF = 16'h7F80;

endpackage
`default_nettype wire

// File: rtl/bf16_adder_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : bf16_adder_driver_if
// | Brief    : Front-end, adder and downstream signals of the bf16 adder driver.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
interface bf16_adder_driver_if;

    bf16_pkg::bf16_t in_a;
    bf16_pkg::bf16_t in_b;
    logic            in_STB;
    logic            in_BUSY;

    bf16_pkg::bf16_t adder_input_a;
    bf16_pkg::bf16_t adder_input_b;
    logic            adder_input_STB;
    logic            adder_BUSY;
    bf16_pkg::bf16_t adder_output_sum;
    logic            adder_output_STB;
    logic            output_module_BUSY;

    bf16_pkg::bf16_t res_data;
    logic            res_STB;
    logic            res_BUSY;

    logic            idle;
    logic [15:0]     issued_cnt;

    // Environment side: front end, adder and result consumer.
    modport master (
        output in_a, in_b, in_STB, adder_BUSY, adder_output_sum, adder_output_STB, res_BUSY,
        input  in_BUSY, adder_input_a, adder_input_b, adder_input_STB, output_module_BUSY,
        input  res_data, res_STB, idle, issued_cnt
    );

    // Driver side.
    modport slave (
        input  in_a, in_b, in_STB, adder_BUSY, adder_output_sum, adder_output_STB, res_BUSY,
        output in_BUSY, adder_input_a, adder_input_b, adder_input_STB, output_module_BUSY,
        output res_data, res_STB, idle, issued_cnt
    );

endinterface
`default_nettype wire

// File: rtl/bf16_adder_driver_stb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : stb_sync_fifo
// | Brief    : Single-clock FIFO with registered count and full/empty flags.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module stb_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int            AW           = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == C_FULL_COUNT);
    assign empty = (r_count == '0);

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign head = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf16_adder_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : bf16_adder_driver
// | Brief    : Buffers operand pairs, issues them one at a time to the bf16
// |            adder over STB/BUSY and collects results in order.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module bf16_adder_driver
    import bf16_pkg::*;
#(
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 4
) (
    input wire logic            clk,
    input wire logic            rst,
    bf16_adder_driver_if.slave  bus
);

    localparam logic [1:0] C_ST_IDLE  = IDLE;
    localparam logic [1:0] C_ST_ISSUE = ISSUE;
    localparam logic [1:0] C_ST_WAIT  = WAIT;

    logic [1:0]  r_state;
    bf16_t       r_a;
    bf16_t       r_b;
    logic        r_stb;
    logic [15:0] r_issued;

    bf16_pair_t  w_op_in;
    bf16_pair_t  w_op_head;
    logic        w_op_full;
    logic        w_op_empty;
    logic        w_op_push;
    logic        w_op_pop;

    bf16_t       w_res_head;
    logic        w_res_full;
    logic        w_res_empty;
    logic        w_res_push;
    logic        w_res_pop;

    assign w_op_in   = '{a: bus.in_a, b: bus.in_b};
    assign w_op_push = bus.in_STB && !w_op_full;
    assign w_op_pop  = (r_state == C_ST_IDLE) && !w_op_empty;

    stb_sync_fifo #(
        .WIDTH ($bits(bf16_pair_t)),
        .DEPTH (OP_DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_op_push),
        .push_data (w_op_in),
        .pop       (w_op_pop),
        .head      (w_op_head),
        .full      (w_op_full),
        .empty     (w_op_empty)
    );

    assign w_res_push = (r_state == C_ST_WAIT) && bus.adder_output_STB && !w_res_full;
    assign w_res_pop  = !w_res_empty && !bus.res_BUSY;

    stb_sync_fifo #(
        .WIDTH (BF16_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_res_push),
        .push_data (bus.adder_output_sum),
        .pop       (w_res_pop),
        .head      (w_res_head),
        .full      (w_res_full),
        .empty     (w_res_empty)
    );

    // One pair outstanding at a time: the next issue waits for the result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= C_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_stb    <= 1'b0;
            r_issued <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (!w_op_empty) begin
                        r_a     <= w_op_head.a;
                        r_b     <= w_op_head.b;
                        r_stb   <= 1'b1;
                        r_state <= C_ST_ISSUE;
                    end
                end
                C_ST_ISSUE: begin
                    if (r_stb && !bus.adder_BUSY) begin
                        r_stb    <= 1'b0;
                        r_issued <= r_issued + 16'd1;
                        r_state  <= C_ST_WAIT;
                    end
                end
                C_ST_WAIT: begin
                    if (bus.adder_output_STB && !w_res_full) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign bus.in_BUSY            = w_op_full;
    assign bus.adder_input_a      = r_a;
    assign bus.adder_input_b      = r_b;
    assign bus.adder_input_STB    = r_stb;
    assign bus.output_module_BUSY = w_res_full;
    assign bus.res_data           = w_res_head;
    assign bus.res_STB            = !w_res_empty;
    assign bus.idle               = (r_state == C_ST_IDLE) && w_op_empty && w_res_empty;
    assign bus.issued_cnt         = r_issued;

    // An adder result outside WAIT is dropped; flag it in simulation.
    a_result_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) bus.adder_output_STB |-> (r_state == C_ST_WAIT)
    );

endmodule
`default_nettype wire
